// File: rtl/s7_display_mux_if.sv
// rtl/s7_display_mux_if.sv - BCD data in / segment and digit-select out bundle for the display mux
interface s7_display_mux_if #(
    parameter int DISPLAYS_NUM = 4
);
    logic [DISPLAYS_NUM*4-1:0] i_bcd_data;
    logic [6:0]                o_segments;
    logic [DISPLAYS_NUM-1:0]   o_segments_sel;

    // Datapath side: supplies digits, observes display pins
    modport master (
        output i_bcd_data,
        input  o_segments,
        input  o_segments_sel
    );

    // Display driver side
    modport slave (
        input  i_bcd_data,
        output o_segments,
        output o_segments_sel
    );
endinterface

// File: rtl/s7_display_mux.sv
// rtl/s7_display_mux.sv - time-multiplexed common-anode 7-segment driver with BCD decode
module s7_display_mux #(
    parameter int DISPLAYS_NUM        = 4,
    parameter int MULTIPLEX_CLK_COUNT = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    s7_display_mux_if.slave      bus
);
    localparam int CNT_W = (MULTIPLEX_CLK_COUNT > 1) ? $clog2(MULTIPLEX_CLK_COUNT) : 1;
    localparam int IDX_W = (DISPLAYS_NUM > 1) ? $clog2(DISPLAYS_NUM) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULTIPLEX_CLK_COUNT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DISPLAYS_NUM - 1);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    // The first edge after reset only loads digit 0 without advancing the
    // dwell counter, so digit 0 gets a full slot like every other digit.
    logic                    scan_run;

    logic [CNT_W-1:0]        cnt_next;
    logic [IDX_W-1:0]        idx_next;
    logic [3:0]              nibble;
    logic [6:0]              seg_next;
    logic [DISPLAYS_NUM-1:0] sel_next;

    // BCD to active-low abcdefg; non-decimal codes are blanked
    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Next dwell count / digit index with explicit wrap, and the output values they select
    always_comb begin
        cnt_next = cnt;
        idx_next = idx;
        if (scan_run) begin
            if (cnt == LAST_CNT) begin
                cnt_next = '0;
                idx_next = (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
        nibble   = bus.i_bcd_data[int'(idx_next)*4 +: 4];
        seg_next = decode(nibble);
        sel_next = ~(DISPLAYS_NUM'(1) << idx_next);
    end

    // Scan state and registered display outputs; reset blanks everything immediately
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt                <= '0;
            idx                <= '0;
            scan_run           <= 1'b0;
            bus.o_segments     <= 7'b1111111;
            bus.o_segments_sel <= '1;
        end else begin
            cnt                <= cnt_next;
            idx                <= idx_next;
            scan_run           <= 1'b1;
            bus.o_segments     <= seg_next;
            bus.o_segments_sel <= sel_next;
        end
    end
endmodule

// File: tb/tb_s7_display_mux.sv
// tb/tb_s7_display_mux.sv - scoreboard bench for s7_display_mux (4 digits, 10-cycle dwell)
module tb_s7_display_mux;
    localparam int DN  = 4;
    localparam int MCC = 10;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic [3:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    s7_display_mux_if #(.DISPLAYS_NUM(DN)) bus ();

    s7_display_mux #(.DISPLAYS_NUM(DN), .MULTIPLEX_CLK_COUNT(MCC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] dec_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;   // clock edges since reset release

    task automatic check(input exp_t e);
        n_cmp++;
        assert (bus.o_segments === e.seg) else begin
            n_bad++;
            $error("FAIL %s seg: got %b want %b (cyc %0d)", e.tag, bus.o_segments, e.seg, cyc);
        end
        n_cmp++;
        assert (bus.o_segments_sel === e.sel) else begin
            n_bad++;
            $error("FAIL %s sel: got %b want %b (cyc %0d)", e.tag, bus.o_segments_sel, e.sel, cyc);
        end
    endtask

    // Drive is already applied; predict this edge's outputs, clock, compare.
    task automatic step(input string tag);
        exp_t e;
        int   d;
        e.tag = tag;
        if (!rst) begin
            e.seg = 7'b1111111;
            e.sel = 4'b1111;
        end else begin
            cyc++;
            d     = ((cyc - 1) / MCC) % DN;
            e.seg = dec_tab[(bus.i_bcd_data >> (d * 4)) & 16'hF];
            e.sel = ~(4'b0001 << d);
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s scoreboard: got empty want entry", tag);
        end else begin
            check(q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic release_rst();
        rst = 1'b1;
        cyc = 0;
    endtask

    initial begin
        exp_t e;
        bus.i_bcd_data = 16'h4321;
        @(negedge clk);

        // 1: held in reset, clocks change nothing
        for (int i = 0; i < 3; i++) step("in_reset");

        // 2: full scan of 4321 plus wrap back to digit 0
        release_rst();
        for (int i = 0; i < 41; i++) step("scan_4321");

        // 3: BCD count 00..19, one value per scan
        for (int v = 0; v < 20; v++) begin
            bus.i_bcd_data = 16'((v / 10) << 4 | (v % 10));
            for (int i = 0; i < 40; i++) step("bcd_count");
        end

        // 4: non-decimal nibbles blank
        bus.i_bcd_data = 16'hFA09;
        for (int i = 0; i < 40; i++) step("blank_FA09");

        // 5: mid-slot data change on digit 0, fresh scan
        rst = 1'b0;
        step("reset_b");
        release_rst();
        bus.i_bcd_data = 16'h0001;
        for (int i = 0; i < 5; i++) step("midslot_pre");
        bus.i_bcd_data = 16'h0008;
        for (int i = 0; i < 8; i++) step("midslot_post");

        // 6: async reset between edges, then full first slot
        rst = 1'b0;
        step("reset_c");
        release_rst();
        bus.i_bcd_data = 16'h4321;
        for (int i = 0; i < 24; i++) step("pre_async");
        #2;
        rst = 1'b0;
        #1;
        e.tag = "async_rst";
        e.seg = 7'b1111111;
        e.sel = 4'b1111;
        check(e);
        @(negedge clk);
        step("async_hold");
        release_rst();
        for (int i = 0; i < 12; i++) step("post_async");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
